gate_selftest_ctrl: RTL and testbench
=====================================

GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

Interface
REQ-001: Parameter CNT_W, default 16, SHALL set the width of the vector-count and error-statistics ports.
REQ-002: Parameter LFSR_SEED, default 16'hACE1, SHALL be the LFSR value loaded at every accepted start.
REQ-003: clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-004: areset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005: start  input  1  is a run request, sampled only in IDLE.
REQ-006: abort  input  1  is a synchronous cancel of a run in progress.
REQ-007: num_vecs  input  CNT_W  is the number of vectors to apply, captured at start.
REQ-008: dut_a, dut_b  output  1 each  are registered stimulus to the 2-input gate under test.
REQ-009: dut_dout  input  1  is the combinational output of the gate under test.
REQ-010: busy  output  1  SHALL be high while in RUN.
REQ-011: done  output  1  SHALL be a one-cycle completion pulse.
REQ-012: pass  output  1  SHALL indicate that the last completed run had zero mismatches.
REQ-013: err_count  output  CNT_W  is the mismatch count of the current or last run.
REQ-014: first_err_idx  output  CNT_W  is the index of the first mismatching vector, or all-ones if none.
REQ-015: vec_count  output  CNT_W  is the number of vectors compared so far.

Function
REQ-016: The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017: IDLE with start=1 and num_vecs>0 SHALL go to RUN; with num_vecs=0 it SHALL go to DONE.
REQ-018: An accepted start SHALL clear err_count, vec_count and pass, set first_err_idx to all-ones, load the LFSR with LFSR_SEED, and drive vector 0 on dut_a/dut_b.
REQ-019: Vector k SHALL be present on {dut_a,dut_b} during the cycle after start-edge+k (one vector per cycle, no bubbles).
REQ-020: Vectors 0..3 SHALL be exhaustive: {dut_a,dut_b} = 00, 01, 10, 11.
REQ-021: Vectors k>=4 SHALL be dut_a=lfsr[0], dut_b=lfsr[1], using a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances once per vector from k=4 onward.
REQ-022: At each RUN edge, the controller SHALL compare dut_dout with the expected value ~(dut_a ^ dut_b) and increment vec_count.
REQ-023: On a mismatch, err_count SHALL increment, saturating at all-ones.
REQ-024: On the first mismatch of a run, first_err_idx SHALL be set to the vector index.
REQ-025: When vector num_vecs-1 has been compared, the FSM SHALL go RUN->DONE and dut_a/dut_b SHALL return to 0.
REQ-026: In DONE, done=1 and pass=(err_count==0) for one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-027: pass, err_count, first_err_idx and vec_count SHALL hold their values until the next accepted start.
REQ-028: start while in RUN or DONE SHALL be ignored (not queued).
REQ-029: abort in RUN SHALL go to IDLE next edge with no done pulse, pass=0, dut_a/dut_b=0, and statistics frozen.
REQ-030: abort outside RUN SHALL have no effect.
REQ-031: If abort and the final compare occur on the same edge, abort SHALL win.
REQ-032: The value of num_vecs captured at start SHALL be used for the whole run; later changes to num_vecs SHALL be ignored.

Reset
REQ-033: areset SHALL immediately force IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, first_err_idx=all-ones, and LFSR=LFSR_SEED, including mid-run.
REQ-034: The first start after areset deasserts SHALL behave identically to a start from power-up.

Verification
REQ-035: Correct XNOR model, num_vecs=14 -> busy high for 14 cycles, done after 14, pass=1, err_count=0, first_err_idx=FFFF, vec_count=14.
REQ-036: XOR model (always wrong), num_vecs=10 -> err_count=10, first_err_idx=0, pass=0.
REQ-037: dut_dout stuck at 0, num_vecs=4 -> vectors 00/01/10/11 with expected 1/0/0/1 -> err_count=2, first_err_idx=0, pass=0.
REQ-038: num_vecs=0 -> done in the cycle after the start edge, busy never high, pass=1, vec_count=0.
REQ-039: areset pulsed during vector 5 of a 20-vector run -> all outputs take their reset values immediately; a new start reproduces vector sequence 00, 01, 10, 11, then the seed-derived vectors.
REQ-040: start pulsed mid-run has no effect; abort at vector 7 -> IDLE, no done, vec_count=7, pass=0.

Source files
------------

// File: rtl/gate_selftest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gate_selftest_ctrl
//  Description : Built-in self-test controller for a 2-input XNOR gate.
//                Applies four exhaustive vectors followed by LFSR-derived
//                vectors, compares the gate output against ~(a ^ b), and
//                keeps mismatch statistics for the last run.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_selftest_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vecs,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_dout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] first_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      lfsr_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    // Next LFSR value: Fibonacci, taps 16,14,13,11, shifting toward bit 0
    logic [15:0]      lfsr_d;
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // cnt_q doubles as the index of the vector currently on the gate inputs
    logic [CNT_W-1:0] idx_nxt_d;
    logic             mismatch_d;
    logic             last_d;
    logic [CNT_W-1:0] err_inc_d;

    assign idx_nxt_d  = cnt_q + CNT_W'(1);
    assign mismatch_d = (dut_dout != ~(a_q ^ b_q));
    assign last_d     = (idx_nxt_d == num_q);
    assign err_inc_d  = (&err_q) ? err_q : err_q + CNT_W'(1);

    // Control FSM with registered stimulus, status and statistics
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            err_q   <= '0;
            first_q <= '1;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_q   <= num_vecs;
                        err_q   <= '0;
                        first_q <= '1;
                        cnt_q   <= '0;
                        lfsr_q  <= LFSR_SEED;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        if (num_vecs != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                        end else begin
                            // Empty run completes immediately with a clean result
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        // Cancel wins over any compare on this edge; stats frozen
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                    end else begin
                        cnt_q <= idx_nxt_d;
                        if (mismatch_d) begin
                            err_q <= err_inc_d;
                            if (err_q == '0) begin
                                first_q <= cnt_q;
                            end
                        end
                        if (last_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (!mismatch_d) && (err_q == '0);
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                        end else if (idx_nxt_d < CNT_W'(4)) begin
                            a_q <= idx_nxt_d[1];
                            b_q <= idx_nxt_d[0];
                        end else begin
                            a_q    <= lfsr_q[0];
                            b_q    <= lfsr_q[1];
                            lfsr_q <= lfsr_d;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_a         = a_q;
    assign dut_b         = b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign vec_count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_selftest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_selftest_ctrl
//  Description : Self-checking bench for gate_selftest_ctrl. A reference
//                vector generator pushes the expected stimulus into a queue
//                before each run; entries are popped and compared as the
//                controller presents them to the modelled gate.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_selftest_ctrl;

    localparam logic [15:0] C_SEED = 16'hACE1;

    logic        clk;
    logic        areset;
    logic        start;
    logic        abort;
    logic [15:0] num_vecs;
    logic        dut_a;
    logic        dut_b;
    logic        dut_dout;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic [15:0] vec_count;

    int          gate_mode;   // 0 = XNOR (correct), 1 = XOR, 2 = stuck at 0
    int          total;
    int          bad;
    logic [1:0]  exp_q[$];

    gate_selftest_ctrl #(
        .CNT_W     (16),
        .LFSR_SEED (C_SEED)
    ) u_dut (
        .clk           (clk),
        .areset        (areset),
        .start         (start),
        .abort         (abort),
        .num_vecs      (num_vecs),
        .dut_a         (dut_a),
        .dut_b         (dut_b),
        .dut_dout      (dut_dout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .vec_count     (vec_count)
    );

    // Gate under test model
    function automatic logic gate_out(input logic [1:0] v, input int md);
        case (md)
            0:       return ~(v[1] ^ v[0]);
            1:       return v[1] ^ v[0];
            default: return 1'b0;
        endcase
    endfunction

    assign dut_dout = gate_out({dut_a, dut_b}, gate_mode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short, so this only fires on a hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  busy,          1'b0);
        check({tag, "_done"},  done,          1'b0);
        check({tag, "_pass"},  pass,          1'b0);
        check({tag, "_err"},   err_count,     16'h0);
        check({tag, "_vcnt"},  vec_count,     16'h0);
        check({tag, "_first"}, first_err_idx, 16'hFFFF);
        check({tag, "_vec"},   {dut_a, dut_b}, 2'b00);
    endtask

    // One run: n vectors against gate model md. abort_at / rst_at / poke_at
    // name the vector index at which abort, areset or a stray start is applied
    // (-1 disables).
    task automatic run_test(input string tag, input int n, input int md,
                            input int abort_at, input int rst_at, input int poke_at);
        logic [15:0] lf;
        logic [1:0]  v;
        int          e_err;
        logic [15:0] e_first;
        gate_mode = md;
        lf        = C_SEED;
        e_err     = 0;
        e_first   = 16'hFFFF;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            if (k < 4) begin
                v = 2'(k);
            end else begin
                v  = {lf[0], lf[1]};
                lf = lfsr_step(lf);
            end
            exp_q.push_back(v);
        end

        num_vecs = 16'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        num_vecs = 16'(n + 5);   // must not affect the run in progress

        for (int k = 0; k < n; k++) begin
            v = exp_q.pop_front();
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_vec"},  {dut_a, dut_b}, v);
            check({tag, "_vcnt"}, vec_count, 16'(k));
            if (k == rst_at) begin
                #2 areset = 1'b1;
                #1;
                check_reset_vals({tag, "_rstnow"});
                @(posedge clk); #1;
                areset = 1'b0;
                check_reset_vals({tag, "_rsthold"});
                @(posedge clk); #1;
                exp_q.delete();
                return;
            end
            if (k == poke_at)  start = 1'b1;
            if (k == abort_at) abort = 1'b1;
            if (k != abort_at && gate_out(v, md) != ~(v[1] ^ v[0])) begin
                if (e_err == 0) e_first = 16'(k);
                e_err++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (k == abort_at) begin
                check({tag, "_ab_busy"},  busy, 1'b0);
                check({tag, "_ab_done"},  done, 1'b0);
                check({tag, "_ab_pass"},  pass, 1'b0);
                check({tag, "_ab_vcnt"},  vec_count, 16'(k));
                check({tag, "_ab_err"},   err_count, 16'(e_err));
                check({tag, "_ab_first"}, first_err_idx, e_first);
                check({tag, "_ab_vec"},   {dut_a, dut_b}, 2'b00);
                @(posedge clk); #1;
                check({tag, "_ab_done2"}, done, 1'b0);
                check({tag, "_ab_vcnt2"}, vec_count, 16'(k));
                exp_q.delete();
                return;
            end
        end

        check({tag, "_done"},  done, 1'b1);
        check({tag, "_busy0"}, busy, 1'b0);
        check({tag, "_pass"},  pass, (e_err == 0));
        check({tag, "_err"},   err_count, 16'(e_err));
        check({tag, "_first"}, first_err_idx, e_first);
        check({tag, "_vcnt"},  vec_count, 16'(n));
        check({tag, "_vec0"},  {dut_a, dut_b}, 2'b00);
        @(posedge clk); #1;
        check({tag, "_done1"}, done, 1'b0);
        check({tag, "_hold_pass"}, pass, (e_err == 0));
        check({tag, "_hold_vcnt"}, vec_count, 16'(n));
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        gate_mode = 0;
        areset    = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        num_vecs  = 16'd0;
        #1;
        check_reset_vals("por");
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("por_idle");

        run_test("xnor14", 14, 0, -1, -1, -1);

        // abort in IDLE must leave everything untouched
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_pass", pass, 1'b1);
        check("idle_abort_vcnt", vec_count, 16'd14);
        check("idle_abort_busy", busy, 1'b0);
        check("idle_abort_done", done, 1'b0);

        run_test("xor10",   10, 1, -1, -1, -1);
        run_test("stuck4",   4, 2, -1, -1, -1);
        run_test("zero",     0, 0, -1, -1, -1);
        run_test("rst20",   20, 0, -1,  5, -1);
        run_test("post_rst", 8, 0, -1, -1, -1);
        run_test("abort20", 20, 0,  7, -1,  3);
        run_test("ab_last",  6, 1,  5, -1, -1);
        run_test("xor_long",30, 1, -1, -1, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
